// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive frame controller.
//   - Frame FSM state encoding (3-bit, legacy-compatible localparams)
//   - Parity type encoding for par_typ
//   - Capture offset: bit decisions are taken at edge_cnt == (prescale>>1) + CAPTURE_OFFSET,
//     one cycle after the sampling stage registers its final sample.
package uart_rx_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int CAPTURE_OFFSET = 2;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART receiver.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = run; 0 = hold both counters at 0 (synchronous clear)
//   bit_en      : 1 = advance bit_cnt at the end of each bit period
//   prescale    : oversampling ratio (8 or 16)
//   edge_cnt    : oversample index within the current bit, 0..prescale-1
//   bit_cnt     : data bit index, 0..DATA_WIDTH-1
//   bit_end     : high while edge_cnt == prescale-1 (last cycle of a bit period)
//   capture     : high while edge_cnt is at the bit-decision point
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 5,
    parameter int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  bit_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  bit_end,
    output logic                  capture
);

    assign bit_end = (edge_cnt == prescale - PRESCALE_W'(1));
    assign capture = (edge_cnt == (prescale >> 1) + PRESCALE_W'(CAPTURE_OFFSET));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (bit_end && bit_en) begin
                if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller. Tracks start/data/parity/stop bit positions,
// drives the oversampling stage (edge_cnt, dat_samp_en), deserializes its
// majority-voted sampled_bit LSB-first, checks parity and stop, and presents
// p_data with a one-cycle data_valid strobe.
// Ports:
//   clk, rst_n   : oversampling clock, asynchronous active-low reset
//   rx_in        : serial line (idle high, already synchronized)
//   prescale     : oversampling ratio, 8 or 16; changed only while idle
//   par_en       : 1 = frame carries a parity bit
//   par_typ      : 0 = even parity, 1 = odd parity
//   sampled_bit  : majority-voted bit from the sampling stage
//   edge_cnt     : oversample index within the current bit
//   dat_samp_en  : sampling-stage enable (high outside IDLE)
//   p_data       : payload of the last good frame
//   data_valid   : one-cycle strobe, p_data updated
//   par_err      : parity mismatch in the current/last frame
//   stp_err      : stop bit sampled low in the current/last frame
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_bit,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [DATA_WIDTH-1:0] shift;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_end;
    logic                  capture;
    logic                  cnt_run;
    logic                  last_bit;

    // The counter runs only while staying inside a frame: it is cleared in
    // IDLE so START begins at 0, and on a START glitch abort so IDLE sees 0.
    assign cnt_run  = (state != IDLE) && (state_next != IDLE);
    assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

    uart_rx_edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (cnt_run),
        .bit_en   (state == DATA),
        .prescale (prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end),
        .capture  (capture)
    );

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_in) state_next = START;
            end
            START: begin
                // A high sample at the decision point means the falling edge was noise.
                if (capture && sampled_bit) state_next = IDLE;
                else if (bit_end)           state_next = DATA;
            end
            DATA: begin
                if (bit_end && last_bit) state_next = par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dat_samp_en <= 1'b0;
            shift       <= '0;
            p_data      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            state       <= state_next;
            dat_samp_en <= (state_next != IDLE);
            data_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    // Flags describe one frame; a new start edge discards the old ones.
                    if (!rx_in) begin
                        par_err <= 1'b0;
                        stp_err <= 1'b0;
                    end
                end
                DATA: begin
                    if (capture) shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
                end
                PARITY: begin
                    if (capture) par_err <= (sampled_bit != (^shift ^ (par_typ == PAR_ODD)));
                end
                STOP: begin
                    if (capture) stp_err <= ~sampled_bit;
                    // Capture precedes bit_end, so both flags are final here.
                    if (bit_end && !par_err && !stp_err) begin
                        p_data     <= shift;
                        data_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl. Frames are generated bit by bit
// on rx_in/sampled_bit; a scoreboard of expected strobes (cycle and payload)
// is built from frame length arithmetic and the parity/stop rules.
module tb_uart_rx_frame_ctrl;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = PAR_EVEN;
    logic          sampled_bit = 1'b1;
    logic [PW-1:0] edge_cnt;
    logic          dat_samp_en;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .sampled_bit (sampled_bit),
        .edge_cnt    (edge_cnt),
        .dat_samp_en (dat_samp_en),
        .p_data      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [DW-1:0] model_pdata = '0;

    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Strobe scoreboard: every data_valid must match the oldest expected strobe
    // in cycle and payload; an expected strobe whose cycle passes is missing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                check("strobe_missing", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    check("strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    check("strobe_cycle", cyc, exp_q[0].cyc);
                    check("strobe_data", 32'(p_data), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        sampled_bit = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // Sends one frame. par_flip corrupts the parity bit, stop_val is the stop
    // bit level, gap is the idle time (>=1 cycle) before flags are checked.
    task automatic send_frame(input logic [DW-1:0] d, input logic par_flip,
                              input logic stop_val, input int gap);
        logic bits[$];
        int   ps;
        int   n;
        logic par_bit;
        logic exp_perr;
        logic exp_serr;
        exp_t e;
        ps       = int'(prescale);
        par_bit  = (($countones(d) % 2) == 1) ^ (par_typ == PAR_ODD) ^ par_flip;
        exp_perr = par_en && par_flip;
        exp_serr = !stop_val;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (par_en) bits.push_back(par_bit);
        bits.push_back(stop_val);
        n = bits.size() * ps;
        // START is entered one cycle after the line drops; the strobe follows
        // a full frame length later.
        if (!exp_perr && !exp_serr) begin
            e.cyc  = cyc + 32'(n) + 1;
            e.data = d;
            exp_q.push_back(e);
            model_pdata = d;
        end
        for (int k = 0; k < n; k++) begin
            rx_in       = bits[k / ps];
            sampled_bit = bits[k / ps];
            if (k >= 1) begin
                check("edge_cnt", 32'(edge_cnt), 32'((k - 1) % ps));
                check("samp_en_frame", 32'(dat_samp_en), 32'd1);
            end
            step();
        end
        idle(gap);
        check("par_err", 32'(par_err), 32'(exp_perr));
        check("stp_err", 32'(stp_err), 32'(exp_serr));
        check("p_data", 32'(p_data), 32'(model_pdata));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_edge_cnt"}, 32'(edge_cnt), 32'd0);
        check({tag, "_samp_en"}, 32'(dat_samp_en), 32'd0);
        check({tag, "_p_data"}, 32'(p_data), 32'd0);
        check({tag, "_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_par_err"}, 32'(par_err), 32'd0);
        check({tag, "_stp_err"}, 32'(stp_err), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        idle(3);

        // 8N1, prescale 8: strobe 80 cycles after START entry
        prescale = PW'(8); par_en = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 3);

        // prescale 16, even parity: good frame then corrupted parity
        prescale = PW'(16); par_en = 1'b1; par_typ = PAR_EVEN;
        send_frame(8'h3C, 1'b0, 1'b1, 3);
        send_frame(8'h3C, 1'b1, 1'b1, 3);

        // prescale 8, odd parity, 0x01 with parity bit 0
        prescale = PW'(8); par_typ = PAR_ODD;
        send_frame(8'h01, 1'b0, 1'b1, 3);

        // Stop bit low
        par_en = 1'b0;
        send_frame(8'h7E, 1'b0, 1'b0, 3);

        // Start glitch: line low 3 cycles; abort at capture point (edge 6)
        for (int k = 0; k < 13; k++) begin
            rx_in       = (k >= 3);
            sampled_bit = (k >= 3);
            if (k >= 1 && k <= 7) begin
                check("glitch_samp_en", 32'(dat_samp_en), 32'd1);
                check("glitch_edge", 32'(edge_cnt), 32'(k - 1));
            end else if (k >= 8) begin
                check("glitch_samp_en", 32'(dat_samp_en), 32'd0);
                check("glitch_edge", 32'(edge_cnt), 32'd0);
            end
            step();
        end
        check("glitch_par_err", 32'(par_err), 32'd0);
        check("glitch_stp_err", 32'(stp_err), 32'd0);
        check("glitch_p_data", 32'(p_data), 32'(model_pdata));

        // Randomized frames with occasional parity/stop corruption
        for (int f = 0; f < 24; f++) begin
            int sel;
            prescale = ($urandom_range(0, 1) == 1) ? PW'(16) : PW'(8);
            par_en   = 1'($urandom_range(0, 1));
            par_typ  = 1'($urandom_range(0, 1));
            sel      = int'($urandom_range(0, 7));
            send_frame(8'($urandom), sel == 0, sel != 1, int'($urandom_range(1, 4)));
        end

        // Reset in the middle of DATA of 0xFF
        prescale = PW'(8); par_en = 1'b0;
        rx_in = 1'b0; sampled_bit = 1'b0;
        for (int k = 0; k < 8; k++) step();
        rx_in = 1'b1; sampled_bit = 1'b1;
        for (int k = 0; k < 26; k++) step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_pdata = '0;
        step();
        step();
        rst_n = 1'b1;
        idle(2);

        // Back-to-back frames after reset
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        send_frame(8'hC3, 1'b0, 1'b1, 4);

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
UART receive frame controller. It sits around the RX data-sampling stage: it drives edge_cnt and dat_samp_en into that stage and consumes its majority-voted sampled_bit. It tracks start/data/parity/stop bit positions, deserializes LSB-first, checks parity and the stop bit, and presents p_data with a one-cycle data_valid pulse.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESCALE_W, 5, width of prescale and edge_cnt

Ports:
clk  in  1  RX oversampling clock
rst_n  in  1  asynchronous active-low reset
rx_in  in  1  serial line; idle high; already synchronized
prescale  in  PRESCALE_W  oversampling ratio; supported values 8 and 16; static while a frame is in flight
par_en  in  1  1 = frame carries a parity bit
par_typ  in  1  0 = even parity, 1 = odd parity
sampled_bit  in  1  majority-voted bit from the sampling stage
edge_cnt  out  PRESCALE_W  oversample index within the current bit
dat_samp_en  out  1  sampling-stage enable
p_data  out  DATA_WIDTH  last good frame payload
data_valid  out  1  one-cycle strobe: p_data updated
par_err  out  1  parity mismatch in the current/last frame
stp_err  out  1  stop bit sampled low in the current/last frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; edge_cnt=0, bit_cnt=0, shift register 0, p_data=0, data_valid=0, par_err=0, stp_err=0, dat_samp_en=0. Reset mid-frame aborts the frame with no strobe.
- States: IDLE, START, DATA, PARITY, STOP.
- dat_samp_en = 1 in every state except IDLE (registered with state).
- Edge counter:
  - held at 0 in IDLE;
  - otherwise increments every clk and wraps from prescale-1 to 0;
  - each wrap ends one bit period.
  - bit_cnt counts data bits 0..DATA_WIDTH-1 in DATA.
- Capture point: edge_cnt == (prescale>>1)+2. The sampling stage registers its last sample at (prescale>>1)+1, so sampled_bit is stable here. Every bit decision is taken only at the capture point.
- IDLE: rx_in==0 -> START on the next cycle with edge_cnt=0. This clears par_err and stp_err.
- START: at the capture point, sampled_bit==1 is a glitch: return to IDLE with no flags and no strobe. Otherwise, at edge_cnt==prescale-1 -> DATA.
- DATA:
  - at the capture point, shift sampled_bit in LSB-first: shift = {sampled_bit, shift[DATA_WIDTH-1:1]};
  - at edge_cnt==prescale-1: if bit_cnt==DATA_WIDTH-1 -> PARITY when par_en=1, else STOP; otherwise bit_cnt++.
- PARITY: at the capture point, expected = ^shift XOR par_typ; par_err <= (sampled_bit != expected). At edge_cnt==prescale-1 -> STOP.
- STOP: at the capture point, stp_err <= ~sampled_bit. At edge_cnt==prescale-1 -> IDLE.
  - If neither flag is set: p_data <= shift, and data_valid is high for exactly the first IDLE cycle.
  - On error: no strobe and p_data is unchanged.
- Latency: data_valid is asserted (1+DATA_WIDTH+par_en+1)*prescale cycles after the first START cycle (80 for 8N1 at prescale=8).
- Error flags: par_err and stp_err hold until the next START entry.
- Back-to-back frames: a start edge arriving in the cycle after STOP is detected in IDLE (one-cycle detection latency, within tolerance).
- par_en, par_typ and prescale changed mid-frame: undefined; software changes them only while idle.

Decomposition:
- Package uart_rx_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit);
  - PAR_EVEN=0 and PAR_ODD=1;
  - capture-offset constant 2.
- Sub-module uart_rx_edge_bit_counter:
  - inputs: clk, rst_n, enable, prescale;
  - outputs: edge_cnt, bit_cnt, a bit_end pulse (edge_cnt==prescale-1), a capture pulse.
- The FSM, deserializer shift register and checkers stay in the top module.

Test Plan:
1. prescale=8, par_en=0, send 0xA5 8N1 -> data_valid high for 1 cycle, 80 cycles after START entry; p_data=0xA5; par_err=stp_err=0.
2. prescale=16, par_en=1, par_typ=0, send 0x3C with parity bit 0 -> p_data=0x3C. Then send 0x3C with parity bit 1 -> par_err=1, no data_valid, p_data stays 0x3C.
3. prescale=8, par_en=1, par_typ=1, send 0x01 with parity bit 0 -> data_valid, p_data=0x01, par_err=0.
4. prescale=8, send 0x7E with stop bit 0 -> stp_err=1 after the STOP capture point; no data_valid; p_data unchanged.
5. prescale=8, rx_in low for 3 cycles then high -> START aborts at the capture point; dat_samp_en falls; no flags, no strobe.
6. Assert rst_n low mid-DATA of 0xFF -> all outputs 0 immediately. After release, back-to-back frames 0x5A and 0xC3 -> two data_valid strobes with the correct p_data.
